divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 32 +++
 rtl/divider.sv | 167 ++++++++++++++++
 tb/tb_divider.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing for the iterative divider
// Purpose: FSM state enum, default operand width and iteration counter width.
// Ports: none (package).
package div_pkg;

  localparam int XLEN_DEFAULT = 64;

  // One extra bit so the counter can hold XLEN itself.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

  localparam int CNT_W = cnt_width(XLEN_DEFAULT);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
// Purpose: shift {rem,quo} left by one, trial-subtract the divisor, keep the
//          difference when non-negative and shift in the quotient bit.
// Ports: rem_in/quo_in/divisor (XLEN) in; rem_out/quo_out (XLEN) out.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] rem_wide;
  logic [XLEN:0] diff;
  logic          ge;
  logic          unused_hi;

  // The shifted remainder needs XLEN+1 bits; the kept value always fits
  // back into XLEN bits because it ends up below the divisor.
  always_comb begin
    rem_wide = {rem_in, quo_in[XLEN-1]};
    diff     = rem_wide - {1'b0, divisor};
    ge       = (rem_wide >= {1'b0, divisor});
    quo_out  = {quo_in[XLEN-2:0], ge};
    rem_out  = ge ? diff[XLEN-1:0] : rem_wide[XLEN-1:0];
  end

  assign unused_hi = diff[XLEN] ^ rem_wide[XLEN];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle restoring divider, signed and unsigned
// Purpose: valid/ready divider; q rounds toward zero, r takes the dividend
//          sign. Divide by zero gives q=all ones, r=a. Optional macro
//          DIVIDER_EARLY_OUT_EN skips the iterations for b==0, signed
//          overflow and |a|<|b|.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, sign, a, b (XLEN);
//        out_valid/out_ready, q, r (XLEN).
module divider
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            sign,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);

  localparam int CW = (XLEN == XLEN_DEFAULT) ? CNT_W : cnt_width(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            sign_q, sign_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] q_q, q_d, r_q, r_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [XLEN-1:0] a_abs, b_abs, step_rem, step_quo;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Magnitudes; the most negative value maps to 2^(XLEN-1) as unsigned,
  // which makes signed overflow come out right without a special case.
  assign a_abs = (sign_q && a_q[XLEN-1]) ? -a_q : a_q;
  assign b_abs = (sign_q && b_q[XLEN-1]) ? -b_q : b_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    r_d         = r_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          sign_d     = sign;
          in_ready_d = 1'b0;
          state_d    = PREP;
        end
      end
      PREP: begin
        qneg_d  = sign_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
        rneg_d  = sign_q & a_q[XLEN-1];
        dz_d    = (b_q == '0);
        quo_d   = a_abs;
        rem_d   = '0;
        dvs_d   = b_abs;
        cnt_d   = '0;
        state_d = ITER;
`ifdef DIVIDER_EARLY_OUT_EN
        // b==0 is resolved in FIX; overflow already has quo=|a|, rem=0.
        if ((b_q == '0) || (a_abs < b_abs) ||
            (sign_q && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1))) begin
          state_d = FIX;
          if (a_abs < b_abs) begin
            quo_d = '0;
            rem_d = a_abs;
          end
        end
`endif
      end
      ITER: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        q_d         = dz_q ? '1  : (qneg_q ? -quo_q : quo_q);
        r_d         = dz_q ? a_q : (rneg_q ? -rem_q : rem_q);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      r_q         <= r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard bench for the divider
module tb_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_NEG = 64'h8000_0000_0000_0000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         sign;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [W-1:0] r;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  int           exp_lat[$];

  divider #(.XLEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model built from language division, special cases first.
  task automatic model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] eq, output logic [W-1:0] er, output int lat);
    logic [W-1:0] aa, bb;
    logic special;
    special = 1'b0;
    if (bv == '0) begin
      eq = '1; er = av; special = 1'b1;
    end else if (s && av == MIN_NEG && bv == '1) begin
      eq = av; er = '0; special = 1'b1;
    end else if (s) begin
      eq = $signed(av) / $signed(bv);
      er = $signed(av) % $signed(bv);
    end else begin
      eq = av / bv;
      er = av % bv;
    end
    aa = (s && av[W-1]) ? -av : av;
    bb = (s && bv[W-1]) ? -bv : bv;
`ifdef DIVIDER_EARLY_OUT_EN
    lat = (special || aa < bb) ? 2 : 66;
`else
    lat = 66 + ((special || aa < bb) ? 0 : 0);
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL wait_ready: in_ready=%0b required 1 within 200 cycles", in_ready);
    end
  endtask

  // Issue one operation; hold out_ready low for 'hold' cycles once out_valid rises.
  task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv, input int hold);
    logic [W-1:0] eq, er, gq, gr, q0, r0;
    int el, gl, edges;
    model(s, av, bv, eq, er, el);
    wait_ready();
    in_valid = 1'b1; sign = s; a = av; b = bv; out_ready = (hold == 0);
    @(posedge clk);
    #1;
    exp_q.push_back(eq); exp_r.push_back(er); exp_lat.push_back(el);
    // Scramble inputs after accept; the DUT must ignore them.
    in_valid = 1'b0; sign = ~s; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    gq = exp_q.pop_front(); gr = exp_r.pop_front(); gl = exp_lat.pop_front();
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL timeout: out_valid=%0b required 1 within 200 edges", out_valid);
    end
    checks++;
    if (edges !== gl) begin
      errors++;
      $display("FAIL latency: got %0d edges required %0d (a=%h b=%h s=%0b)", edges, gl, av, bv, s);
    end
    checks++;
    if (q !== gq) begin
      errors++;
      $display("FAIL quotient: got %h required %h (a=%h b=%h s=%0b)", q, gq, av, bv, s);
    end
    checks++;
    if (r !== gr) begin
      errors++;
      $display("FAIL remainder: got %h required %h (a=%h b=%h s=%0b)", r, gr, av, bv, s);
    end
    q0 = q; r0 = r;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (q !== q0 || r !== r0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: q=%h r=%h ov=%0b ir=%0b required q=%h r=%h ov=1 ir=0",
                 q, r, out_valid, in_ready, q0, r0);
      end
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_handshake: in_ready=%0b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sign = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== '0 || r !== '0) begin
      errors++;
      $display("FAIL reset: ir=%0b ov=%0b q=%h r=%h required 1/0/0/0", in_ready, out_valid, q, r);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    run_op(1'b0, 64'd100, 64'd7, 0);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0);
    run_op(1'b0, 64'd5, 64'd9, 0);
  endtask

  task automatic test_signed();
    run_op(1'b1, -64'sd7, 64'd2, 0);
    run_op(1'b1, 64'd7, -64'sd2, 0);
    run_op(1'b1, -64'sd100, -64'sd7, 0);
  endtask

  task automatic test_div_zero();
    run_op(1'b0, 64'h0000_0000_FFFF_FFFF, 64'd0, 0);
    run_op(1'b1, 64'h0000_0000_FFFF_FFFF, 64'd0, 0);
    run_op(1'b1, -64'sd5, 64'd0, 0);
  endtask

  task automatic test_overflow();
    run_op(1'b1, MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 0);
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 64'd1000, 64'd33, 10);
  endtask

  task automatic test_reset_mid_iter();
    int seen = 0;
    wait_ready();
    in_valid = 1'b1; sign = 1'b0; a = 64'd12345; b = 64'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_iter: ir=%0b ov=%0b required 1/0", in_ready, out_valid);
    end
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL aborted_result: out_valid high %0d cycles required 0", seen);
    end
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av, bv;
    logic s;
    for (int i = 0; i < 6; i++) begin
      s  = 1'($urandom_range(0, 1));
      av = {$urandom, $urandom};
      bv = (i % 2 == 0) ? {32'd0, $urandom} : 64'($urandom_range(1, 1000));
      run_op(s, av, bv, 0);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_iter();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
